// File: rtl/uart_frame_check.sv
// UART receive frame checker: deserialises LSB-first data, checks optional parity and
// 1 or 2 stop bits, and keeps sticky flags and saturating error counters.
module uart_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  sample_strobe,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy,
    output logic                  par_err_sticky,
    output logic                  stop_err_sticky,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;

    localparam logic [3:0]           LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t     state;
    state_t     state_next;
    logic [3:0] bit_cnt;
    logic       par_en_q;
    logic       par_odd_q;
    logic       data_xor;
    logic       par_fail;
    logic       stop_fail;

    logic strobe_ok;
    logic data_last;
    logic stop_last;
    logic stop_fail_next;

    // frame_start takes priority over a coincident strobe
    assign strobe_ok      = sample_strobe && !frame_start;
    assign data_last      = strobe_ok && (state == DATA) && (bit_cnt == LAST_DATA);
    assign stop_last      = strobe_ok && (state == STOP) && (bit_cnt == LAST_STOP);
    assign stop_fail_next = stop_fail || (strobe_ok && (state == STOP) && !sampled_bit);

    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (frame_start) state_next = DATA;
            end
            DATA: begin
                if (frame_start)    state_next = DATA;
                else if (data_last) state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (frame_start)    state_next = DATA;
                else if (strobe_ok) state_next = STOP;
            end
            STOP: begin
                if (frame_start)    state_next = DATA;
                else if (stop_last) state_next = DONE;
            end
            DONE: begin
                state_next = frame_start ? DATA : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-frame datapath; frame results are latched on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            data_xor  <= 1'b0;
            par_fail  <= 1'b0;
            stop_fail <= 1'b0;
            p_data    <= '0;
            par_err   <= 1'b0;
            stop_err  <= 1'b0;
        end else if (frame_start) begin
            bit_cnt   <= '0;
            par_en_q  <= par_en;
            par_odd_q <= par_odd;
            data_xor  <= 1'b0;
            par_fail  <= 1'b0;
            stop_fail <= 1'b0;
            p_data    <= '0;
            par_err   <= 1'b0;
            stop_err  <= 1'b0;
        end else if (strobe_ok) begin
            case (state)
                DATA: begin
                    p_data   <= {sampled_bit, p_data[DATA_WIDTH-1:1]};
                    data_xor <= data_xor ^ sampled_bit;
                    bit_cnt  <= data_last ? 4'd0 : bit_cnt + 4'd1;
                end
                PARITY: begin
                    par_fail <= (sampled_bit != (data_xor ^ par_odd_q));
                end
                STOP: begin
                    stop_fail <= stop_fail_next;
                    bit_cnt   <= stop_last ? 4'd0 : bit_cnt + 4'd1;
                    if (stop_last) begin
                        par_err  <= par_fail;
                        stop_err <= stop_fail_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status: an error reported in DONE beats a simultaneous err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_sticky  <= 1'b0;
            stop_err_sticky <= 1'b0;
            par_err_cnt     <= '0;
            stop_err_cnt    <= '0;
        end else begin
            if (frame_done && par_err)  par_err_sticky <= 1'b1;
            else if (err_clr)           par_err_sticky <= 1'b0;

            if (frame_done && stop_err) stop_err_sticky <= 1'b1;
            else if (err_clr)           stop_err_sticky <= 1'b0;

            if (err_clr)
                par_err_cnt <= (frame_done && par_err) ? CNT_ONE : '0;
            else if (frame_done && par_err && (par_err_cnt != CNT_MAX))
                par_err_cnt <= par_err_cnt + CNT_ONE;

            if (err_clr)
                stop_err_cnt <= (frame_done && stop_err) ? CNT_ONE : '0;
            else if (frame_done && stop_err && (stop_err_cnt != CNT_MAX))
                stop_err_cnt <= stop_err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: one-stop and two-stop instances share stimulus;
// a table of frames plus hand-written corner sequences, scored through queues.
module tb_uart_frame_check;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic sample_strobe = 1'b0;
    logic sampled_bit = 1'b0;
    logic par_en = 1'b0;
    logic par_odd = 1'b0;
    logic err_clr = 1'b0;

    logic       fd1, pe1, se1, busy1, pes1, ses1;
    logic [7:0] pd1, pec1, sec1;
    logic       fd2, pe2, se2, busy2, pes2, ses2;
    logic [7:0] pd2, pec2, sec2;

    always #5 clk = ~clk;

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sample_strobe(sample_strobe),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd), .err_clr(err_clr),
        .frame_done(fd1), .p_data(pd1), .par_err(pe1), .stop_err(se1), .busy(busy1),
        .par_err_sticky(pes1), .stop_err_sticky(ses1), .par_err_cnt(pec1), .stop_err_cnt(sec1)
    );

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sample_strobe(sample_strobe),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd), .err_clr(err_clr),
        .frame_done(fd2), .p_data(pd2), .par_err(pe2), .stop_err(se2), .busy(busy2),
        .par_err_sticky(pes2), .stop_err_sticky(ses2), .par_err_cnt(pec2), .stop_err_cnt(sec2)
    );

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         podd;
        bit         pbit;
        bit         stop;
        bit         exp_pe;
        bit         exp_se;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         se;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    bit   mon1 = 1'b0;
    bit   mon2 = 1'b0;
    int   done_cnt1 = 0;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: every frame_done pops the frame the stimulus predicted
    always @(negedge clk) begin
        exp_t e;
        if (mon1 && fd1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_p_data", pd1, e.data);
                check("dut1_par_err", pe1, e.pe);
                check("dut1_stop_err", se1, e.se);
            end
        end
        if (mon2 && fd2) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("dut2_p_data", pd2, e.data);
                check("dut2_par_err", pe2, e.pe);
                check("dut2_stop_err", se2, e.se);
            end
        end
    end

    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        frame_start = 1'b0;
        sample_strobe = 1'b0;
        err_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        q1.delete();
        q2.delete();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        check("queue_drained", q1.size() + q2.size(), 0);
    endtask

    // Drives one frame; tgt selects which instance owns the prediction (2 => two stop bits)
    task automatic send_frame(input int tgt, input logic [7:0] data, input bit pen, input bit podd,
                              input bit pbit, input bit s0, input bit s1,
                              input bit exp_pe, input bit exp_se, input bit clr_in_done);
        exp_t e;
        tick();
        frame_start = 1'b1;
        par_en = pen;
        par_odd = podd;
        sample_strobe = 1'b1;
        sampled_bit = ~data[0];
        tick();
        frame_start = 1'b0;
        sample_strobe = 1'b0;
        par_en = ~pen;
        par_odd = ~podd;
        for (int i = 0; i < 8; i++) begin
            tick();
            sample_strobe = 1'b1;
            sampled_bit = data[i];
            tick();
            sample_strobe = 1'b0;
        end
        if (pen) begin
            tick();
            sample_strobe = 1'b1;
            sampled_bit = pbit;
            tick();
            sample_strobe = 1'b0;
        end
        e.data = data;
        e.pe = exp_pe;
        e.se = exp_se;
        if (tgt == 1) q1.push_back(e);
        else q2.push_back(e);
        tick();
        sample_strobe = 1'b1;
        sampled_bit = s0;
        if (tgt == 2) begin
            tick();
            sample_strobe = 1'b0;
            @(negedge clk);
            check("dut2_no_done_after_first_stop", fd2, 1'b0);
            tick();
            sample_strobe = 1'b1;
            sampled_bit = s1;
        end
        tick();
        sample_strobe = 1'b0;
        if (clr_in_done) err_clr = 1'b1;
        @(negedge clk);
        check("done_latency", (tgt == 1) ? fd1 : fd2, 1'b1);
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("done_one_cycle", (tgt == 1) ? fd1 : fd2, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        int run_pe;
        int run_se;
        int exp_sat;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        #3;
        check("reset_frame_done", fd1, 1'b0);
        check("reset_busy", busy1, 1'b0);
        check("reset_p_data", pd1, 8'h00);
        check("reset_errs", {pe1, se1, pes1, ses1}, 4'b0000);
        check("reset_cnts", {pec1, sec1}, 16'h0000);
        apply_reset();

        // Table of single-stop frames with running error counts
        mon1 = 1'b1;
        run_pe = 0;
        run_se = 0;
        for (int i = 0; i < 8; i++) begin
            send_frame(1, vecs[i].data, vecs[i].pen, vecs[i].podd, vecs[i].pbit,
                       vecs[i].stop, 1'b1, vecs[i].exp_pe, vecs[i].exp_se, 1'b0);
            run_pe += int'(vecs[i].exp_pe);
            run_se += int'(vecs[i].exp_se);
            check("par_err_cnt", pec1, run_pe);
            check("stop_err_cnt", sec1, run_se);
            check("par_sticky", pes1, (run_pe != 0));
            check("stop_sticky", ses1, (run_se != 0));
        end
        drain();

        // err_clr clears status but leaves frame results alone
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_cnts", {pec1, sec1}, 16'h0000);
        check("clr_sticky", {pes1, ses1}, 2'b00);
        check("clr_keeps_p_data", pd1, 8'h81);
        check("clr_keeps_par_err", pe1, 1'b1);

        // Two stop bits
        mon1 = 1'b0;
        apply_reset();
        mon2 = 1'b1;
        send_frame(2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("dut2_stop_cnt_a", sec2, 8'd1);
        send_frame(2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(2, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("dut2_stop_cnt_b", sec2, 8'd2);
        check("dut2_stop_sticky", ses2, 1'b1);
        drain();
        mon2 = 1'b0;

        // Saturation then err_clr coinciding with an error DONE
        apply_reset();
        mon1 = 1'b1;
        for (int i = 0; i < 300; i++)
            send_frame(1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_sat = 255;
        check("stop_cnt_saturated", sec1, exp_sat);
        check("par_cnt_untouched", pec1, 8'd0);
        send_frame(1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("clr_in_done_cnt", sec1, 8'd1);
        check("clr_in_done_sticky", ses1, 1'b1);
        drain();

        // Abort after four data strobes, then a clean frame
        apply_reset();
        done_cnt1 = 0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            sample_strobe = 1'b1;
            sampled_bit = 1'b0;
            tick();
            sample_strobe = 1'b0;
        end
        send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        check("abort_single_done", done_cnt1, 1);
        check("abort_no_counts", {pec1, sec1}, 16'h0000);
        drain();

        // Asynchronous reset mid-frame
        apply_reset();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            sample_strobe = 1'b1;
            sampled_bit = 1'b1;
            tick();
            sample_strobe = 1'b0;
        end
        check("pre_reset_busy", busy1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", busy1, 1'b0);
        check("async_p_data", pd1, 8'h00);
        check("async_done", fd1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        send_frame(1, 8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        mon1 = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
